// File: rtl/gray_conv_sched_if.sv
// -----------------------------------------------------------------------------
// gray_conv_sched_if
// Bundles the requester-side and output-side signals of gray_conv_sched.
//   req0_valid/req0_gray/req0_ready : requester 0 handshake and Gray word
//   req1_valid/req1_gray/req1_ready : requester 1 handshake and Gray word
//   out_valid/out_ready/out_binary/out_id : converted result handshake
//   done_cnt0/done_cnt1 : saturating per-requester completion counters
//   busy : converter is holding a result
// modport slave  : the converter itself
// modport master : the environment (requesters plus consumer)
// -----------------------------------------------------------------------------
interface gray_conv_sched_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_gray;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_gray;
  logic             req1_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_binary;
  logic             out_id;
  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;
  logic             busy;

  modport slave (
    input  req0_valid, req0_gray, req1_valid, req1_gray, out_ready,
    output req0_ready, req1_ready, out_valid, out_binary, out_id,
           done_cnt0, done_cnt1, busy
  );

  modport master (
    output req0_valid, req0_gray, req1_valid, req1_gray, out_ready,
    input  req0_ready, req1_ready, out_valid, out_binary, out_id,
           done_cnt0, done_cnt1, busy
  );
endinterface

// File: rtl/gray_conv_sched.sv
// -----------------------------------------------------------------------------
// gray_conv_sched
// Two-requester Gray-to-binary converter with a single output slot.
// In IDLE one valid requester is granted (round-robin pointer breaks ties),
// its word is converted and registered, and the block sits in HOLD until the
// consumer takes the result. Each completed handshake bumps a saturating
// counter for the owning requester.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active high
//   bus : gray_conv_sched_if.slave (request, result and status signals)
// -----------------------------------------------------------------------------
module gray_conv_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  gray_conv_sched_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;       // 0 favours requester 0 on contention
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             grant0, grant1;

  // Prefix XOR from the MSB downwards.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Requester-side arbitration; only meaningful in IDLE.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);

  // Gated by rst so a requester never sees an accept while reset is held,
  // even if the state register still reads IDLE from before.
  assign bus.req0_ready = (state_q == IDLE) & grant0 & ~rst;
  assign bus.req1_ready = (state_q == IDLE) & grant1 & ~rst;

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.busy       = (state_q == HOLD);
  assign bus.out_binary = bin_q;
  assign bus.out_id     = id_q;
  assign bus.done_cnt0  = cnt0_q;
  assign bus.done_cnt1  = cnt1_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    id_d    = id_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          state_d = HOLD;
          bin_d   = gray2bin(grant1 ? bus.req1_gray : bus.req0_gray);
          id_d    = grant1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          ptr_d   = ~id_q;
          if (id_q == 1'b0) begin
            if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + 1'b1;
          end else begin
            if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      bin_q   <= '0;
      id_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

endmodule

// File: doc/gray_conv_sched.md
GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary code width in bits; WIDTH SHALL be 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each per-requester completion counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, on the following ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active high.
REQ-004 The block SHALL have the following requester-side ports:
- req0_valid  input  1  requester 0 presents a Gray word.
- req0_gray  input  WIDTH  requester 0 Gray code.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 presents a Gray word.
- req1_gray  input  WIDTH  requester 1 Gray code.
- req1_ready  output  1  requester 1 word accepted this cycle.
REQ-005 The block SHALL have the following output-side ports:
- out_valid  output  1  converted result available.
- out_ready  input  1  consumer accepts result.
- out_binary  output  WIDTH  converted binary value.
- out_id  output  1  requester index (0/1) owning out_binary.
- done_cnt0  output  CNT_W  completed conversions for requester 0.
- done_cnt1  output  CNT_W  completed conversions for requester 1.
- busy  output  1  high when state is HOLD.

Function
REQ-006 The block SHALL implement a two-state FSM: IDLE and HOLD.
REQ-007 The conversion SHALL be binary[WIDTH-1] = gray[WIDTH-1], and binary[i] = binary[i+1] XOR gray[i] for i < WIDTH-1.
REQ-008 In IDLE, when at least one reqN_valid is high, the block SHALL grant exactly one requester in that cycle, as follows:
- Grant = the only valid requester if only one is valid.
- Grant = the requester selected by the priority pointer if both are valid.
REQ-009 On a grant in IDLE, the block SHALL, in the same cycle:
- assert reqN_ready for the granted requester only;
- register the converted Gray word into out_binary and N into out_id;
- set out_valid for the next cycle and move to HOLD.
REQ-010 reqN_ready SHALL be combinational, equal to (state==IDLE) AND grant_N; it SHALL be low in HOLD and for any non-granted requester.
REQ-011 Latency from an accepted request to out_valid SHALL be exactly 1 cycle.
REQ-012 In HOLD, out_valid SHALL stay high and out_binary/out_id SHALL stay stable until the cycle in which out_ready is high.
REQ-013 On an out_valid AND out_ready cycle, the block SHALL, in that cycle:
- return to IDLE and drop out_valid for the next cycle;
- set the priority pointer to the requester other than out_id;
- increment done_cnt[out_id] by 1.
REQ-014 No new request SHALL be accepted in the cycle of the output handshake; maximum throughput SHALL be one conversion per 2 cycles.
REQ-015 done_cnt0/done_cnt1 SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-016 Changes on reqN_valid/reqN_gray while in HOLD SHALL have no effect on the outputs.
REQ-017 busy SHALL equal (state==HOLD).

Reset
REQ-018 When rst is high at a clock edge, the block SHALL, on that edge:
- enter IDLE and clear out_valid, out_binary, out_id, done_cnt0, done_cnt1;
- set the priority pointer to requester 0.
REQ-019 While rst is high, req0_ready and req1_ready SHALL be low.
REQ-020 A reset asserted in HOLD SHALL discard the pending result; it SHALL not be counted or presented after reset.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single request: reset, then req0_valid=1, req0_gray=4'b1011, out_ready=1 -> req0_ready=1 in that cycle; next cycle out_valid=1, out_binary=4'b1101, out_id=0; done_cnt0=1 after the handshake.
- Contention: both valid, req0_gray=4'b0110, req1_gray=4'b1000, out_ready=1 -> out_binary=4'b0100 with id 0 first, then 4'b1111 with id 1; alternation continues while both stay valid.
- Back-pressure: out_ready=0 for 5 cycles after a grant -> out_valid stays 1, out_binary stable, both reqN_ready=0, busy=1; releasing out_ready -> out_valid=0 next cycle.
- Reset mid-operation: assert rst in HOLD -> next cycle out_valid=0, counters 0, pointer favours req0 on the following contention.
- Saturation (CNT_W=2): 5 completed req1 conversions -> done_cnt1=3.
- Exhaustive conversion: all 16 Gray codes through req0 -> out_binary matches the reference prefix-XOR for each.
